sram_byte_loader: RTL

//  Write-side counterpart to the clocked-read ROM/SRAM: fills memory at run time instead of via $readmemh.

---
 rtl/sram_byte_loader_pkg.sv | 15 +
 rtl/sram_byte_loader_if.sv | 39 +++
 rtl/sram_byte_loader_assembler.sv | 60 ++++++
 rtl/sram_byte_loader.sv | 118 +++++++++++
 4 files changed

// File: rtl/sram_byte_loader_pkg.sv
// Shared definitions for the SRAM byte loader: FSM state type and word geometry helper.
package sram_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_t;

  function automatic int bytes_per_word(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/sram_byte_loader_if.sv
// Byte-stream input, SRAM write port and status signals of the SRAM byte loader.
// o_checksum exists only when SRAM_LOADER_CHECKSUM_EN is defined.
interface sram_byte_loader_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 10
);

  logic                     i_start;
  logic [ADDRESS_WIDTH-1:0] i_base_addr;
  logic [ADDRESS_WIDTH:0]   i_word_count;
  logic                     i_byte_valid;
  logic [7:0]               i_byte;
  logic                     o_byte_ready;
  logic                     o_wr_en;
  logic [ADDRESS_WIDTH-1:0] o_wr_addr;
  logic [DATA_WIDTH-1:0]    o_wr_data;
  logic                     o_busy;
  logic                     o_done;
`ifdef SRAM_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]    o_checksum;
`endif

  modport master (
    output i_start, i_base_addr, i_word_count, i_byte_valid, i_byte,
    input  o_byte_ready, o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done
`ifdef SRAM_LOADER_CHECKSUM_EN
    , input o_checksum
`endif
  );

  modport slave (
    input  i_start, i_base_addr, i_word_count, i_byte_valid, i_byte,
    output o_byte_ready, o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done
`ifdef SRAM_LOADER_CHECKSUM_EN
    , output o_checksum
`endif
  );

endinterface

// File: rtl/sram_byte_loader_assembler.sv
// Packs incoming bytes little-endian into one word. word_o already includes the
// byte being accepted this cycle, so the owner can latch a complete word on the
// same edge that accepts its last byte (word_full_o).
module sram_word_assembler
  import sram_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  clear_i,
  input  logic                  accept_i,
  input  logic [7:0]            byte_i,
  output logic [DATA_WIDTH-1:0] word_o,
  output logic                  word_full_o
);

  localparam int BPW = bytes_per_word(DATA_WIDTH);
  localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] pack_q;

  // Merge the accepted byte into its lane and flag completion of the word
  always_comb begin
    word_o = pack_q;
    for (int k = 0; k < BPW; k++) begin
      if (accept_i && (idx_q == IW'(k))) begin
        word_o[8*k +: 8] = byte_i;
      end
    end
    word_full_o = accept_i && (idx_q == IW'(BPW - 1));
  end

  // Byte index advances per accepted byte and restarts after a full word or a clear
  always_comb begin
    idx_d = idx_q;
    if (clear_i) begin
      idx_d = '0;
    end else if (accept_i) begin
      idx_d = word_full_o ? '0 : idx_q + 1'b1;
    end
  end

  // Index and pack register; a clear discards any partial word
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      idx_q  <= '0;
      pack_q <= '0;
    end else begin
      idx_q <= idx_d;
      if (clear_i) begin
        pack_q <= '0;
      end else if (accept_i) begin
        pack_q <= word_o;
      end
    end
  end

endmodule

// File: rtl/sram_byte_loader.sv
// SRAM byte loader: accepts a byte stream, packs bytes little-endian into words and
// writes them to consecutive SRAM addresses from a programmable base (wrapping).
// Optional feature macro: SRAM_LOADER_CHECKSUM_EN adds a running word checksum output.
module sram_byte_loader
  import sram_loader_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 10
) (
  input  logic i_clk,
  input  logic i_rstn,
  sram_byte_loader_if.slave bus
);

  loader_state_t            state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [ADDRESS_WIDTH:0]   remaining_q, remaining_d;
  logic [ADDRESS_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;

  logic                     startAccept;
  logic                     byteAccept;
  logic [DATA_WIDTH-1:0]    asmWord;
  logic                     wordFull;

  assign startAccept = (state_q == ST_IDLE) && bus.i_start;
  assign byteAccept  = (state_q == ST_LOAD) && bus.i_byte_valid;

  sram_word_assembler #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_assembler (
    .clk_i       (i_clk),
    .rstn_i      (i_rstn),
    .clear_i     (startAccept),
    .accept_i    (byteAccept),
    .byte_i      (bus.i_byte),
    .word_o      (asmWord),
    .word_full_o (wordFull)
  );

  // Sequencing: capture parameters on start, latch each full word, step address and count per write
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          addr_d      = bus.i_base_addr;
          remaining_d = bus.i_word_count;
          state_d     = (bus.i_word_count == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (wordFull) begin
          wr_addr_d = addr_q;
          wr_data_d = asmWord;
          state_d   = ST_WRITE;
        end
      end
      ST_WRITE: begin
        addr_d      = addr_q + 1'b1;
        remaining_d = remaining_q - 1'b1;
        state_d     = (remaining_q == (ADDRESS_WIDTH + 1)'(1)) ? ST_DONE : ST_LOAD;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, address, count and the registered write port; reset discards any load in flight
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign bus.o_byte_ready = (state_q == ST_LOAD);
  assign bus.o_wr_en      = (state_q == ST_WRITE);
  assign bus.o_done       = (state_q == ST_DONE);
  assign bus.o_busy       = (state_q != ST_IDLE);
  assign bus.o_wr_addr    = wr_addr_q;
  assign bus.o_wr_data    = wr_data_q;

`ifdef SRAM_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q;

  // Running sum of written words, restarted by each accepted start
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      csum_q <= '0;
    end else if (startAccept) begin
      csum_q <= '0;
    end else if (state_q == ST_WRITE) begin
      csum_q <= csum_q + wr_data_q;
    end
  end

  assign bus.o_checksum = csum_q;
`endif

endmodule
